// File: rtl/mix_column.sv
// AES MixColumns / InvMixColumns over a 128-bit column-major state.
// Combinational result on out_test plus a one-cycle registered copy with a valid flag.
module mix_column (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in,
    input  logic         dec,
    input  logic         in_valid,
    output logic [127:0] out_test,
    output logic [127:0] out_q,
    output logic         out_valid
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        mul3 = xtime(a) ^ a;
    endfunction

    // Inverse coefficients share one x, x^2, x^3 chain per byte.
    function automatic logic [31:0] inv_terms(input logic [7:0] a);
        logic [7:0] x1, x2, x3;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        // packed as {9a, Ba, Da, Ea}
        inv_terms = {x3 ^ a, x3 ^ x1 ^ a, x3 ^ x2 ^ a, x3 ^ x2 ^ x1};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a0, a1, a2, a3;
        logic [31:0] t0, t1, t2, t3;
        logic [31:0] fwd, rev;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        fwd = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
               mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
        t0 = inv_terms(a0);
        t1 = inv_terms(a1);
        t2 = inv_terms(a2);
        t3 = inv_terms(a3);
        // byte lanes of t*: [31:24]=9, [23:16]=B, [15:8]=D, [7:0]=E
        rev = {t0[7:0]   ^ t1[23:16] ^ t2[15:8]  ^ t3[31:24],
               t0[31:24] ^ t1[7:0]   ^ t2[23:16] ^ t3[15:8],
               t0[15:8]  ^ t1[31:24] ^ t2[7:0]   ^ t3[23:16],
               t0[23:16] ^ t1[15:8]  ^ t2[31:24] ^ t3[7:0]};
        mix_col = inv ? rev : fwd;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign out_test[127-32*gi -: 32] = mix_col(in[127-32*gi -: 32], dec);
        end
    endgenerate

    logic [127:0] out_d;
    assign out_d = in_valid ? out_test : out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= 128'h0;
            out_valid <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: combinational vectors, round trips and the register stage.
module tb_mix_column;

    logic         clk;
    logic         rst_n;
    logic [127:0] in;
    logic         dec;
    logic         in_valid;
    logic [127:0] out_test;
    logic [127:0] out_q;
    logic         out_valid;

    int total = 0;
    int bad   = 0;
    logic [127:0] sb_q[$];
    logic [127:0] last_q;

    mix_column dut (
        .clk(clk), .rst_n(rst_n), .in(in), .dec(dec), .in_valid(in_valid),
        .out_test(out_test), .out_q(out_q), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] m [4][4];
        logic [7:0] a [4];
        logic [7:0] b;
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int k = 0; k < 4; k++)
                if (!inv) m[row][(row + k) % 4] = (k == 0) ? 8'h02 : (k == 1) ? 8'h03 : 8'h01;
                else      m[row][(row + k) % 4] = (k == 0) ? 8'h0E : (k == 1) ? 8'h0B :
                                                   (k == 2) ? 8'h0D : 8'h09;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h0;
                for (int k = 0; k < 4; k++) b = b ^ gmul(m[row][k], a[k]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in = 128'h0; dec = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (out_q !== 128'h0) begin bad++; $display("FAIL reset_out_q got=%h exp=0", out_q); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        $display("reset: out_q=%h out_valid=%b", out_q, out_valid);
    endtask

    task automatic comb_check(input string name, input logic [127:0] s, input logic d,
                              input logic [127:0] exp);
        in = s; dec = d;
        #1;
        total++;
        if (out_test !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, out_test, exp);
        end else
            $display("%s: in=%h dec=%b out=%h", name, s, d, out_test);
    endtask

    task automatic test_vectors();
        logic [127:0] v4;
        comb_check("enc_full", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                   128'h046681e5e0cb199a48f8d37a2806264c);
        comb_check("dec_full", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5);
        comb_check("enc_cols", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
                   128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        v4 = 128'hd4d4d4d52d26314c0000000000000000;
        in = v4; dec = 1'b0;
        #1;
        total++;
        if (out_test[127:64] !== 64'hd5d5d7d64d7ebdf8) begin
            bad++;
            $display("FAIL enc_cols2 got=%h exp=d5d5d7d64d7ebdf8", out_test[127:64]);
        end else
            $display("enc_cols2: in=%h out=%h", v4, out_test);
    endtask

    task automatic test_round_trip();
        logic [127:0] s, e;
        for (int i = 0; i < 20; i++) begin
            s = rand128();
            in = s; dec = 1'b0;
            #1;
            e = out_test;
            total++;
            if (e !== model(s, 1'b0)) begin
                bad++;
                $display("FAIL rt_enc[%0d] got=%h exp=%h", i, e, model(s, 1'b0));
            end
            in = e; dec = 1'b1;
            #1;
            total++;
            if (out_test !== s) begin
                bad++;
                $display("FAIL rt_dec[%0d] got=%h exp=%h", i, out_test, s);
            end else
                $display("round_trip[%0d]: s=%h enc=%h", i, s, e);
        end
        comb_check("zero_enc", 128'h0, 1'b0, 128'h0);
        comb_check("zero_dec", 128'h0, 1'b1, 128'h0);
        comb_check("ff_enc", {128{1'b1}}, 1'b0, {128{1'b1}});
        comb_check("ff_dec", {128{1'b1}}, 1'b1, {128{1'b1}});
    endtask

    task automatic pop_check(input string name);
        logic [127:0] exp;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s_sb got=empty_queue exp=entry", name);
            return;
        end
        exp = sb_q.pop_front();
        if (out_valid !== 1'b1 || out_q !== exp) begin
            bad++;
            $display("FAIL %s got=%h/%b exp=%h/1", name, out_q, out_valid, exp);
        end else
            $display("%s: out_q=%h out_valid=%b", name, out_q, out_valid);
        last_q = exp;
    endtask

    task automatic test_back_to_back();
        logic [127:0] s;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = rand128();
            in = s; dec = i[0]; in_valid = 1'b1;
            sb_q.push_back(model(s, i[0]));
            @(posedge clk); #1;
            pop_check($sformatf("b2b[%0d]", i));
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        in = rand128(); dec = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || out_q !== last_q) begin
                bad++;
                $display("FAIL hold[%0d] got=%h/%b exp=%h/0", i, out_q, out_valid, last_q);
            end else
                $display("hold[%0d]: out_q=%h out_valid=%b", i, out_q, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] s;
        @(negedge clk);
        s = rand128();
        in = s; dec = 1'b0; in_valid = 1'b1;
        sb_q.push_back(model(s, 1'b0));
        @(posedge clk); #1;
        pop_check("pre_rst");
        @(negedge clk);
        s = rand128();
        in = s; dec = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_q !== 128'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%h/%b exp=0/0", out_q, out_valid);
        end else
            $display("async_rst: out_q=%h out_valid=%b", out_q, out_valid);
        total++;
        if (out_test !== model(s, 1'b1)) begin
            bad++;
            $display("FAIL rst_comb got=%h exp=%h", out_test, model(s, 1'b1));
        end
        @(posedge clk); #1;
        total++;
        if (out_q !== 128'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_held got=%h/%b exp=0/0", out_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_q !== 128'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_idle got=%h/%b exp=0/0", out_q, out_valid);
        end
        @(negedge clk);
        s = rand128();
        in = s; dec = 1'b1; in_valid = 1'b1;
        sb_q.push_back(model(s, 1'b1));
        @(posedge clk); #1;
        pop_check("first_after_rst");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_q = 128'h0;
        test_reset();
        test_vectors();
        test_round_trip();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_column.md
# mix_column

AES MixColumns / InvMixColumns transform over a full 128-bit state, selectable per operation by a decrypt flag. It sits in the AES round datapath after ShiftRows (encrypt) or AddRoundKey (decrypt). It provides a zero-latency combinational result for the round logic and a one-cycle registered copy with a valid flag for pipelined use.

## Interface
- No parameters.
- clk  input  1  rising-edge clock for the registered output stage.
- rst_n  input  1  asynchronous reset, active-low; clears registered outputs.
- in  input  128  AES state; in[127:120] = byte 0, in[7:0] = byte 15.
- dec  input  1  0 = MixColumns (encrypt), 1 = InvMixColumns (decrypt).
- in_valid  input  1  qualifies `in`/`dec` for capture into the register stage.
- out_test  output  128  combinational transform of `in` under `dec`; same byte order as `in`.
- out_q  output  128  registered transform, captured when in_valid = 1.
- out_valid  output  1  high one cycle after a cycle with in_valid = 1.

## Operation
- State layout is column-major per FIPS-197. Column c (0..3) = bytes 4c..4c+3, MSB-first, i.e. in[127-32c -: 32]. Row 0 is the most significant byte of the column.
- Each column (a0,a1,a2,a3) maps independently to (b0,b1,b2,b3) using GF(2^8) arithmetic. The field polynomial is x^8+x^4+x^3+x+1 (0x11B). Addition is XOR.
- xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00). Multiplication by 03, 09, 0B, 0D and 0E is built from xtime chains and XOR. There are no lookup tables and no general multiplier.
- dec = 0: b0 = 2a0^3a1^a2^a3; b1 = a0^2a1^3a2^a3; b2 = a0^a1^2a2^3a3; b3 = 3a0^a1^a2^2a3.
- dec = 1: b0 = Ea0^Ba1^Da2^9a3; b1 = 9a0^Ea1^Ba2^Da3; b2 = Da0^9a1^Ea2^Ba3; b3 = Ba0^Da1^9a2^Ea3.
- For any state s, InvMix(Mix(s)) = s.
- out_test is purely combinational from `in` and `dec`. It is independent of clk, rst_n and in_valid, and is valid immediately after the inputs settle.
- There are no X-generating paths. All 2^128 inputs produce defined outputs.

## Timing
- Combinational path: out_test responds in the same cycle. A bench must see it correct within half a cycle of an input change.
- Register stage, on rising clk when rst_n = 1:
  - if in_valid: out_q <= f(in, dec), out_valid <= 1.
  - else: out_q holds its value, out_valid <= 0.
- Latency for out_q is 1 cycle. Throughput is one state per cycle with back-to-back in_valid allowed.
- `dec` is sampled together with `in` on the capturing edge. A mode change between consecutive valid cycles takes effect for the next captured state only.
- Reset: rst_n low asynchronously forces out_q = 128'h0 and out_valid = 0, regardless of clk. A reset asserted mid-stream discards the pending result. The first capture after release occurs on the first rising edge with rst_n = 1 and in_valid = 1.
- out_test is unaffected by reset.

## Test plan
- Encrypt, full state: dec = 0, in = d4bf5d30e0b452aeb84111f11e2798e5 -> out_test = 046681e5e0cb199a48f8d37a2806264c.
- Decrypt, full state: dec = 1, in = 046681e5e0cb199a48f8d37a2806264c -> out_test = d4bf5d30e0b452aeb84111f11e2798e5.
- Column vectors, dec = 0, in = db135345f20a225c01010101c6c6c6c6 -> 8e4da1bc9fdc589d01010101c6c6c6c6.
- Column vectors, dec = 0, in = d4d4d4d52d26314c... -> leading words d5d5d7d6 and 4d7ebdf8.
- Round trip: for 20 random states, feed the encrypt output into dec = 1 and require the original state; also check all-zero -> zero and all-FF -> all-FF in both modes.
- Register stage:
  - Assert rst_n = 0 mid-stream -> out_q = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - After release, drive in_valid for 3 back-to-back cycles with alternating dec -> out_q and out_valid follow exactly one cycle later with the matching per-cycle mode.
  - Drive in_valid = 0 -> out_valid = 0 and out_q holds its last value.
